// File: rtl/text_console_writer_pkg.sv
// Shared character codes, geometry defaults and FSM encodings for the text console path.
// The renderer will import the same state encodings.
package text_console_writer_pkg;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BLANK = 8'h20;

    localparam int DEF_COLS_LOG2 = 5;
    localparam int DEF_ROWS      = 30;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUT     = 3'd1,
        ST_SCR_RD  = 3'd2,
        ST_SCR_WR  = 3'd3,
        ST_SCR_CLR = 3'd4,
        ST_CLR_ALL = 3'd5
    } tcw_state_e;

    typedef enum logic [2:0] {
        K_PRINT,
        K_CR,
        K_LF,
        K_BS,
        K_FF
    } byte_kind_e;

    function automatic byte_kind_e classify(input logic [7:0] c);
        case (c)
            CHAR_CR: return K_CR;
            CHAR_LF: return K_LF;
            CHAR_BS: return K_BS;
            CHAR_FF: return K_FF;
            default: return K_PRINT;
        endcase
    endfunction

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream console writer: decodes control codes, tracks the cursor and drives the
// single text RAM port for character writes, one-line scroll and full-screen clear.
module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter int             A         = 10,
    parameter int             D         = 8,
    parameter int             COLS_LOG2 = DEF_COLS_LOG2,
    parameter int             ROWS      = DEF_ROWS,
    parameter logic [D-1:0]   BLANK     = D'(CHAR_BLANK)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic [D-1:0]           in_data,
    output logic                   in_ready,
    output logic                   ram_we,
    output logic [A-1:0]           ram_addr,
    output logic [D-1:0]           ram_din,
    input  logic [D-1:0]           ram_dout,
    output logic [COLS_LOG2-1:0]   cursor_col,
    output logic [A-COLS_LOG2-1:0] cursor_row,
    output logic                   busy
);

    localparam int ROW_W = A - COLS_LOG2;
    localparam int COLS  = 1 << COLS_LOG2;

    localparam logic [A-1:0]         SCR_FIRST     = A'(COLS);
    localparam logic [A-1:0]         LAST_ADDR     = A'(ROWS * COLS - 1);
    localparam logic [A-1:0]         LAST_ROW_BASE = A'((ROWS - 1) * COLS);
    localparam logic [ROW_W-1:0]     LAST_ROW      = ROW_W'(ROWS - 1);
    localparam logic [COLS_LOG2-1:0] LAST_COL      = COLS_LOG2'(COLS - 1);

    tcw_state_e           state_q, state_d;
    logic [A-1:0]         ptr_q, ptr_d;
    logic [COLS_LOG2-1:0] col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 we_q, we_d;
    logic [A-1:0]         addr_q, addr_d;
    logic [D-1:0]         din_q, din_d;

    // Valid/ready: a byte transfers on a posedge where in_valid && in_ready; in_ready is
    // high only in IDLE, and in_valid is ignored in every other state.
    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = ~in_ready;
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

    // The RAM read data arrives during SCR_WR itself, so it is forwarded straight to the
    // write port to keep a line move at two cycles per character.
    assign ram_din = (state_q == ST_SCR_WR) ? ram_dout : din_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        col_d   = col_q;
        row_d   = row_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (classify(8'(in_data)))
                        K_CR: col_d = '0;
                        K_LF: begin
                            col_d = '0;
                            if (row_q != LAST_ROW) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                state_d = ST_SCR_RD;
                                ptr_d   = SCR_FIRST;
                                addr_d  = SCR_FIRST;
                            end
                        end
                        K_BS: begin
                            if (col_q != '0) col_d = col_q - 1'b1;
                        end
                        K_FF: begin
                            state_d = ST_CLR_ALL;
                            ptr_d   = '0;
                            we_d    = 1'b1;
                            addr_d  = '0;
                            din_d   = BLANK;
                        end
                        default: begin
                            state_d = ST_PUT;
                            we_d    = 1'b1;
                            addr_d  = {row_q, col_q};
                            din_d   = in_data;
                        end
                    endcase
                end
            end

            ST_PUT: begin
                state_d = ST_IDLE;
                if (col_q != LAST_COL) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d = '0;
                    if (row_q != LAST_ROW) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        state_d = ST_SCR_RD;
                        ptr_d   = SCR_FIRST;
                        addr_d  = SCR_FIRST;
                    end
                end
            end

            ST_SCR_RD: begin
                state_d = ST_SCR_WR;
                we_d    = 1'b1;
                addr_d  = ptr_q - SCR_FIRST;
            end

            ST_SCR_WR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_SCR_CLR;
                    ptr_d   = LAST_ROW_BASE;
                    we_d    = 1'b1;
                    addr_d  = LAST_ROW_BASE;
                    din_d   = BLANK;
                end else begin
                    state_d = ST_SCR_RD;
                    ptr_d   = ptr_q + 1'b1;
                    addr_d  = ptr_q + 1'b1;
                end
            end

            ST_SCR_CLR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d  = ptr_q + 1'b1;
                    we_d   = 1'b1;
                    addr_d = ptr_q + 1'b1;
                    din_d  = BLANK;
                end
            end

            ST_CLR_ALL: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    ptr_d  = ptr_q + 1'b1;
                    we_d   = 1'b1;
                    addr_d = ptr_q + 1'b1;
                    din_d  = BLANK;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a behavioural 1024x8 text RAM and a
// screen-level reference model of the console.
module tb_text_console_writer;
    import text_console_writer_pkg::*;

    localparam int NCOLS = 32;
    localparam int NROWS = 30;
    localparam int VIS   = NCOLS * NROWS;
    localparam int GUARD = 5000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [4:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    text_console_writer dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 73 + 19) ^ (i >> 4));
    endfunction

    // Text RAM: registered read, write on posedge; preloaded on the first edge.
    logic [7:0] mem [0:1023];
    logic       mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
            mem_loaded <= 1'b1;
        end else begin
            ram_dout <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_din;
        end
    end

    int we_count = 0;
    int high_writes = 0;
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_count <= we_count + 1;
            if (ram_addr >= 10'(VIS)) high_writes <= high_writes + 1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_mem [0:1023];
    logic [17:0] exp_q[$];
    int         m_row = 0;
    int         m_col = 0;

    typedef struct {
        logic [7:0] data;
        logic [4:0] row;
        logic [4:0] col;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_screen(input string name);
        int bad;
        bad = 0;
        checks++;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== exp_mem[i]) begin
                if (bad == 0)
                    $display("FAIL %s: addr %0d got %0h expected %0h", name, i, mem[i], exp_mem[i]);
                bad++;
            end
        end
        if (bad != 0) errors++;
    endtask

    task automatic check_cursor(input string name, input int row, input int col);
        check({name, "_row"}, 32'(cursor_row), 32'(row));
        check({name, "_col"}, 32'(cursor_col), 32'(col));
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out after %0d cycles, expected completion", name, GUARD);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_scroll();
        for (int a = 0; a < VIS - NCOLS; a++) exp_mem[a] = exp_mem[a + NCOLS];
        for (int a = VIS - NCOLS; a < VIS; a++) exp_mem[a] = CHAR_BLANK;
    endtask

    task automatic model_apply(input logic [7:0] b);
        case (b)
            CHAR_CR: m_col = 0;
            CHAR_LF: begin
                m_col = 0;
                if (m_row < NROWS - 1) m_row++;
                else model_scroll();
            end
            CHAR_BS: if (m_col > 0) m_col--;
            CHAR_FF: begin
                for (int a = 0; a < VIS; a++) exp_mem[a] = CHAR_BLANK;
                m_row = 0;
                m_col = 0;
            end
            default: begin
                exp_mem[m_row * NCOLS + m_col] = b;
                exp_q.push_back({10'(m_row * NCOLS + m_col), b});
                if (m_col < NCOLS - 1) begin
                    m_col++;
                end else begin
                    m_col = 0;
                    if (m_row < NROWS - 1) m_row++;
                    else model_scroll();
                end
            end
        endcase
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (!in_ready && g < GUARD) begin
            step();
            g++;
        end
        if (g >= GUARD) timeout_fail(name);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && g < GUARD) begin
            step();
            g++;
        end
        if (g >= GUARD) timeout_fail("send_wait_ready");
        step();
        in_valid = 1'b0;
        model_apply(b);
    endtask

    task automatic sb_step();
        if (ram_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_write: got write %0h@%0d expected no write", ram_din, ram_addr);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_din} !== e) begin
                    errors++;
                    $display("FAIL sb_write: got %0h@%0d expected %0h@%0d",
                             ram_din, ram_addr, e[7:0], e[17:8]);
                end
            end
        end
    endtask

    initial begin
        int cnt;
        int we_base;
        logic [7:0] stream [40];

        for (int i = 0; i < 1024; i++) exp_mem[i] = init_byte(i);

        vecs[0]  = '{8'h61,   5'd1, 5'd1};
        vecs[1]  = '{8'h62,   5'd1, 5'd2};
        vecs[2]  = '{CHAR_BS, 5'd1, 5'd1};
        vecs[3]  = '{CHAR_CR, 5'd1, 5'd0};
        vecs[4]  = '{CHAR_BS, 5'd1, 5'd0};
        vecs[5]  = '{CHAR_LF, 5'd2, 5'd0};
        vecs[6]  = '{8'h63,   5'd2, 5'd1};
        vecs[7]  = '{CHAR_LF, 5'd3, 5'd0};
        vecs[8]  = '{8'h78,   5'd3, 5'd1};
        vecs[9]  = '{8'h79,   5'd3, 5'd2};
        vecs[10] = '{CHAR_BS, 5'd3, 5'd1};
        vecs[11] = '{CHAR_BS, 5'd3, 5'd0};
        vecs[12] = '{CHAR_BS, 5'd3, 5'd0};

        // Reset state
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check_cursor("rst", 0, 0);

        // 'H','i' back to back with valid held
        in_valid = 1'b1;
        in_data  = 8'h48;
        step();
        check("hi_ready_after_h", 32'(in_ready), 32'd0);
        in_data = 8'h69;
        step();
        check("hi_ready_back", 32'(in_ready), 32'd1);
        step();
        check("hi_ready_after_i", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        model_apply(8'h48);
        model_apply(8'h69);
        wait_idle("hi_idle");
        step();
        check("hi_ram0", 32'(mem[0]), 32'h48);
        check("hi_ram1", 32'(mem[1]), 32'h69);
        check_cursor("hi", 0, 2);

        // Full row 0 of printables
        send_byte(CHAR_CR);
        check_cursor("cr_row0", 0, 0);
        for (int i = 0; i < NCOLS; i++) send_byte(8'(8'h41 + (i % 26)));
        wait_idle("row0_idle");
        step();
        check("row0_addr31", 32'(mem[31]), 32'h46);
        check("row0_addr0", 32'(mem[0]), 32'h41);
        check_cursor("row0_wrap", 1, 0);

        // Cursor control table
        for (int v = 0; v < 13; v++) begin
            send_byte(vecs[v].data);
            wait_idle("vec_idle");
            check($sformatf("vec%0d_row", v), 32'(cursor_row), 32'(vecs[v].row));
            check($sformatf("vec%0d_col", v), 32'(cursor_col), 32'(vecs[v].col));
        end
        step();
        check_screen("vec_screen");

        // Scroll on LF at the bottom row
        for (int i = 0; i < 26; i++) send_byte(CHAR_LF);
        check_cursor("bottom", 29, 0);
        for (int i = 0; i < NCOLS - 1; i++) send_byte(8'(8'h30 + (i % 10)));
        wait_idle("row29_idle");
        check_cursor("row29_fill", 29, 31);
        send_byte(CHAR_LF);
        cnt = 0;
        while (busy && cnt < GUARD) begin
            cnt++;
            step();
        end
        check("scroll_busy_cycles", 32'(cnt), 32'd1888);
        step();
        check_cursor("scroll", 29, 0);
        check("scroll_row28_col5", 32'(mem[28 * NCOLS + 5]), 32'h35);
        check("scroll_row29_col0", 32'(mem[29 * NCOLS]), 32'h20);
        check("scroll_row0_col0", 32'(mem[0]), 32'h61);
        check_screen("scroll_screen");

        // Form feed clear
        we_base = we_count;
        send_byte(CHAR_FF);
        wait_idle("ff_idle");
        step();
        check("ff_write_count", 32'(we_count - we_base), 32'd960);
        check_cursor("ff", 0, 0);
        check("ff_addr959", 32'(mem[959]), 32'h20);
        check("ff_addr960", 32'(mem[960]), 32'(init_byte(960)));
        check_screen("ff_screen");

        // Reset in the middle of a scroll
        for (int i = 0; i < 29; i++) send_byte(CHAR_LF);
        check_cursor("bottom2", 29, 0);
        send_byte(CHAR_LF);
        repeat (500) step();
        check("mid_scroll_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        step();
        check("abort_ram_we", 32'(ram_we), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check_cursor("abort", 0, 0);
        resetn = 1'b1;
        m_row = 0;
        m_col = 0;
        send_byte(8'h5A);
        wait_idle("abort_z_idle");
        step();
        check("abort_z_addr0", 32'(mem[0]), 32'h5A);
        check_cursor("abort_z", 0, 1);
        send_byte(CHAR_FF);
        wait_idle("ff2_idle");
        step();
        check_screen("ff2_screen");

        // Randomly toggled valid against busy, writes scoreboarded in order
        for (int i = 0; i < 40; i++) begin
            if (i % 9 == 4) stream[i] = CHAR_BS;
            else if (i % 13 == 7) stream[i] = CHAR_CR;
            else stream[i] = 8'(8'h41 + $urandom_range(0, 25));
        end
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            logic accepted;
            logic acc_now;
            int g;
            accepted = 1'b0;
            g = 0;
            in_data = stream[i];
            while (!accepted && g < GUARD) begin
                in_valid = 1'($urandom_range(0, 1));
                acc_now  = in_valid && in_ready;
                step();
                if (acc_now) begin
                    model_apply(stream[i]);
                    accepted = 1'b1;
                end
                sb_step();
                g++;
            end
            if (!accepted) timeout_fail("rand_accept");
        end
        in_valid = 1'b0;
        repeat (4) begin
            step();
            sb_step();
        end
        check("rand_queue_left", 32'(exp_q.size()), 32'd0);
        check("rand_cursor_row", 32'(cursor_row), 32'(m_row));
        check("rand_cursor_col", 32'(cursor_col), 32'(m_col));
        check_screen("rand_screen");

        check("high_addr_writes", 32'(high_writes), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
